// File: rtl/rs232_des_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM,
// level req/ack byte handoff (clk, rst_n, rx -> rx_data, rx_req; rx_ack).
module rs232_des_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_req,
  input  logic       rx_ack
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sr;
  logic          stop_ok;

  // Preset high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sr      <= '0;
      stop_ok <= 1'b0;
      rx_data <= 8'h00;
      rx_req  <= 1'b0;
    end else begin
      stop_ok <= 1'b0;

      // A completed frame wins over ack; overrun drops the new byte.
      if (stop_ok && (!rx_req || rx_ack)) begin
        rx_data <= sr;
        rx_req  <= 1'b1;
      end else if (rx_req && rx_ack) begin
        rx_req  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            sr  <= {rx_s, sr[7:1]};
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              stop_ok <= 1'b1;
              state   <= IDLE;
            end else begin
              state   <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_des_rx.sv
// Directed bench for rs232_des_rx at 16 clocks per bit.
// Immediate assertions on handshake, data, latency and error cases.
module tb_rs232_des_rx;

  localparam int CLK_FREQ  = 100000000;
  localparam int BAUD_RATE = 6250000;
  localparam int BITC      = CLK_FREQ / BAUD_RATE;
  localparam int HALFC     = BITC / 2;
  localparam int LAT_NOM   = 2 + HALFC + 9 * BITC + 1;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_req;
  logic       rx_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  int t_rise = -1;
  int lat;
  logic req_prev = 1'b0;

  rs232_des_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .rx_data(rx_data),
    .rx_req (rx_req),
    .rx_ack (rx_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_req && !req_prev && t_rise < 0) t_rise = cyc;
    req_prev = rx_req;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bits(input int n);
    repeat (n * BITC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    t_start = cyc;
    t_rise = -1;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    rx = stop;
    repeat (BITC) @(negedge clk);
  endtask

  task automatic ack_pulse(input int n);
    rx_ack = 1'b1;
    repeat (n) @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    rx_ack = 1'b0;
    #100;
    chk("rst_req", {7'd0, rx_req}, 8'h00);
    chk("rst_data", rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bits(3);
    chk("idle_req", {7'd0, rx_req}, 8'h00);

    send_frame(8'h55, 1'b1);
    chk("f1_req", {7'd0, rx_req}, 8'h01);
    chk("f1_data", rx_data, 8'h55);
    lat = t_rise - t_start;
    checks++;
    assert (t_rise >= 0 && lat >= LAT_NOM && lat <= LAT_NOM + 1) else begin
      errors++;
      $error("FAIL f1_latency observed=%0d expected=%0d..%0d",
             lat, LAT_NOM, LAT_NOM + 1);
    end
    ack_pulse(1);
    chk("f1_ack_req", {7'd0, rx_req}, 8'h00);
    chk("f1_ack_data", rx_data, 8'h55);

    send_frame(8'hAA, 1'b1);
    chk("f2_req", {7'd0, rx_req}, 8'h01);
    chk("f2_data", rx_data, 8'hAA);
    ack_pulse(3);
    chk("f2_ack_req", {7'd0, rx_req}, 8'h00);
    bits(3);
    chk("f2_idle_req", {7'd0, rx_req}, 8'h00);

    rx = 1'b0;
    repeat (HALFC / 2) @(negedge clk);
    rx = 1'b1;
    bits(3);
    chk("glitch_req", {7'd0, rx_req}, 8'h00);
    chk("glitch_data", rx_data, 8'hAA);

    send_frame(8'h3C, 1'b0);
    bits(2);
    rx = 1'b1;
    bits(2);
    chk("ferr_req", {7'd0, rx_req}, 8'h00);
    chk("ferr_data", rx_data, 8'hAA);

    send_frame(8'h81, 1'b1);
    chk("f81_req", {7'd0, rx_req}, 8'h01);
    chk("f81_data", rx_data, 8'h81);
    ack_pulse(1);
    chk("f81_ack_req", {7'd0, rx_req}, 8'h00);
    bits(1);

    send_frame(8'h12, 1'b1);
    chk("ovr1_req", {7'd0, rx_req}, 8'h01);
    chk("ovr1_data", rx_data, 8'h12);
    send_frame(8'h34, 1'b1);
    chk("ovr2_req", {7'd0, rx_req}, 8'h01);
    chk("ovr2_data", rx_data, 8'h12);
    ack_pulse(1);
    chk("ovr_ack_req", {7'd0, rx_req}, 8'h00);
    chk("ovr_ack_data", rx_data, 8'h12);
    bits(1);

    rx = 1'b0;
    bits(1);
    rx = 1'b1;
    bits(3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_req", {7'd0, rx_req}, 8'h00);
    chk("mrst_data", rx_data, 8'h00);
    rst_n = 1'b1;
    bits(12);
    chk("mrst_idle_req", {7'd0, rx_req}, 8'h00);

    send_frame(8'hC3, 1'b1);
    chk("fc3_req", {7'd0, rx_req}, 8'h01);
    chk("fc3_data", rx_data, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
